boot_rom_arbiter: RTL

Two-port round-robin arbiter sharing the single-ported boot ROM between the core instruction fetch port (m0) and the debug/data port (m1). Uses a req/gnt/rvalid handshake on each master side and drives the ROM's chip-select, address and read-data pins, whose read latency is one cycle. Out-of-range accesses complete with an error instead of touching the ROM. A saturating conflict counter supports boot-time profiling.

---
 rtl/boot_rom_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/boot_rom_arbiter.sv
// Round-robin arbiter sharing a single-ported, one-cycle-latency boot ROM between
// the instruction fetch master (m0) and the debug/data master (m1).
module boot_rom_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int ROM_DEPTH  = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH+1:0] m0_addr_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    output logic                  m0_err_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH+1:0] m1_addr_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  m1_err_o,
    output logic                  rom_csn_o,
    output logic [ADDR_WIDTH-1:0] rom_a_o,
    input  logic [31:0]           rom_q_i,
    output logic [15:0]           conflict_cnt_o
);

    // Handshake: a master holds req (and a stable address) until it sees gnt in the
    // same cycle; exactly one cycle after gnt it sees rvalid with rdata/err.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(ROM_DEPTH);

    logic                  prio;        // 0: m0 wins a tie, 1: m1 wins a tie
    logic                  prio_next;
    logic                  gnt0;
    logic                  gnt1;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] win_idx;
    logic                  win_in_range;
    logic                  rsp_valid;
    logic                  rsp_owner;
    logic                  rsp_err;
    logic [15:0]           conflict_cnt;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

    // Priority pointer: state register
    always_ff @(posedge CLK) begin
        if (RST) prio <= 1'b0;
        else     prio <= prio_next;
    end

    // Priority pointer: next state, moves to the other master after any grant
    always_comb begin
        prio_next = prio;
        if (gnt0)      prio_next = 1'b1;
        else if (gnt1) prio_next = 1'b0;
    end

    // Grant and ROM-side outputs
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            if (m0_req_i && (!m1_req_i || !prio)) gnt0 = 1'b1;
            else if (m1_req_i)                    gnt1 = 1'b1;
        end
        gnt_any      = gnt0 | gnt1;
        win_idx      = gnt1 ? m1_addr_i[ADDR_WIDTH+1:2] : m0_addr_i[ADDR_WIDTH+1:2];
        win_in_range = ({1'b0, win_idx} < DEPTH_LIM);
        rom_csn_o    = !(gnt_any && win_in_range);
        rom_a_o      = (gnt_any && win_in_range) ? win_idx : '0;
    end

    assign m0_gnt_o = gnt0;
    assign m1_gnt_o = gnt1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid    <= 1'b0;
            rsp_owner    <= 1'b0;
            rsp_err      <= 1'b0;
            conflict_cnt <= 16'd0;
        end else begin
            rsp_valid <= gnt_any;
            if (gnt_any) begin
                rsp_owner <= gnt1;
                rsp_err   <= !win_in_range;
            end
            if (m0_req_i && m1_req_i && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

    // Response outputs; masked during reset so a grant just before reset never completes
    always_comb begin
        m0_rvalid_o    = !RST && rsp_valid && !rsp_owner;
        m1_rvalid_o    = !RST && rsp_valid && rsp_owner;
        m0_err_o       = m0_rvalid_o && rsp_err;
        m1_err_o       = m1_rvalid_o && rsp_err;
        m0_rdata_o     = (m0_rvalid_o && !rsp_err) ? rom_q_i : 32'd0;
        m1_rdata_o     = (m1_rvalid_o && !rsp_err) ? rom_q_i : 32'd0;
        conflict_cnt_o = RST ? 16'd0 : conflict_cnt;
    end

endmodule
